// File: rtl/dram_cache.sv
// dram_cache: direct-mapped, write-through, read-allocate one-word-per-line
// cache in front of a 32-bit DRAM request port. Read hits return in one
// cycle; read misses and every store become a single DRAM transaction.
module dram_cache #(
    parameter int LINES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        calib_done,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_we,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        dram_oe,
    output logic [31:0] dram_addr,
    output logic [31:0] dram_wdata,
    output logic [3:0]  dram_we,
    input  logic [31:0] dram_rdata,
    input  logic        dram_valid,
    input  logic        dram_busy
);
    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = 30 - IDX;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t             state, state_nx;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_mem [LINES];
    logic [31:0]        data_mem [LINES];

    // Context of the transaction currently out at DRAM
    logic               pend_write;
    logic [IDX-1:0]     pend_idx;
    logic [TAG_W-1:0]   pend_tag;

    logic [IDX-1:0]     idx;
    logic [TAG_W-1:0]   tag;
    logic               hit, accept, is_write, read_hit, go_issue;
    logic               read_done, write_done;
    logic [1:0]         off;
    logic               addr_unused;

    // Index of the lowest enabled byte lane; becomes the DRAM byte offset
    function automatic logic [1:0] lowest_lane(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else if (m[3]) return 2'd3;
        else           return 2'd0;
    endfunction

    // Replace the enabled byte lanes of a cached word with store data
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  m);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    assign addr_unused = ^req_addr[1:0];
    assign idx        = req_addr[2 +: IDX];
    assign tag        = req_addr[31 -: TAG_W];
    assign hit        = valid[idx] && (tag_mem[idx] == tag);
    assign is_write   = |req_we;
    assign off        = lowest_lane(req_we);
    assign req_ready  = (state == IDLE) & calib_done & ~dram_busy & ~flush;
    assign accept     = req_valid & req_ready;
    assign read_hit   = accept & ~is_write & hit;
    assign go_issue   = accept & (is_write | ~hit);
    assign read_done  = (state == WAIT) & ~pend_write & dram_valid;
    assign write_done = (state == WAIT) & pend_write & ~dram_busy;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // FSM next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (go_issue) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (read_done || write_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Registered outputs and line valid bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            dram_oe    <= 1'b0;
            dram_addr  <= '0;
            dram_wdata <= '0;
            dram_we    <= '0;
            valid      <= '0;
        end else begin
            resp_valid <= read_hit | read_done | write_done;
            if (read_hit)       resp_rdata <= data_mem[idx];
            else if (read_done) resp_rdata <= dram_rdata;
            else                resp_rdata <= '0;
            dram_oe <= go_issue;
            if (go_issue) begin
                dram_addr  <= {req_addr[31:2], off};
                dram_we    <= req_we >> off;
                dram_wdata <= req_wdata >> {off, 3'b000};
            end
            if (state == IDLE && flush) valid <= '0;
            else if (read_done)         valid[pend_idx] <= 1'b1;
        end
    end

    // Tag/data storage and pending-transaction context (not reset)
    always_ff @(posedge clk) begin
        if (go_issue) begin
            pend_write <= is_write;
            pend_idx   <= idx;
            pend_tag   <= tag;
        end
        if (accept && is_write && hit) begin
            data_mem[idx] <= merge_bytes(data_mem[idx], req_wdata, req_we);
        end
        if (read_done) begin
            tag_mem[pend_idx]  <= pend_tag;
            data_mem[pend_idx] <= dram_rdata;
        end
    end
endmodule

// File: tb/tb_dram_cache.sv
// Testbench for dram_cache: directed requests push expected responses and
// DRAM transactions into queues; a monitor pops and compares them.
module tb_dram_cache;
    logic        clk = 0;
    logic        rst_n;
    logic        calib_done, flush, req_valid, req_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_we;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        dram_oe;
    logic [31:0] dram_addr, dram_wdata;
    logic [3:0]  dram_we;
    logic [31:0] dram_rdata;
    logic        dram_valid, dram_busy;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wd;
        logic        chk_wd;
    } dreq_t;

    logic [31:0] exp_resp[$];
    dreq_t       exp_dram[$];
    int          total = 0;
    int          bad = 0;

    // DRAM model controls
    int          lat = 5;
    logic [31:0] ret_data = 0;

    dram_cache #(.LINES(64)) dut (
        .clk(clk), .rst_n(rst_n), .calib_done(calib_done), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .dram_oe(dram_oe), .dram_addr(dram_addr),
        .dram_wdata(dram_wdata), .dram_we(dram_we), .dram_rdata(dram_rdata),
        .dram_valid(dram_valid), .dram_busy(dram_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // DRAM responder: busy rises the cycle after dram_oe and lasts lat cycles;
    // reads return data with a one-cycle dram_valid as busy falls.
    initial begin
        logic launch, cur_rd;
        logic [31:0] cur_ret;
        int cnt;
        launch = 0; cur_rd = 0; cur_ret = 0; cnt = 0;
        dram_busy = 0; dram_valid = 0; dram_rdata = 0;
        forever begin
            @(posedge clk); #1;
            dram_valid = 0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    dram_busy = 0;
                    if (cur_rd) begin
                        dram_valid = 1;
                        dram_rdata = cur_ret;
                    end
                end
            end
            if (launch) begin
                launch = 0;
                dram_busy = 1;
                cnt = lat;
            end
            if (dram_oe === 1'b1) begin
                launch = 1;
                cur_rd = (dram_we == 4'b0000);
                cur_ret = ret_data;
            end
        end
    end

    // Monitor: compare every response and DRAM request against the queues
    initial begin
        logic prev_oe;
        prev_oe = 0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (resp_valid === 1'b1) begin
                    if (exp_resp.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_resp: got rdata %h want no response", resp_rdata);
                    end else begin
                        check("resp_rdata", resp_rdata, exp_resp.pop_front());
                    end
                end
                if (dram_oe === 1'b1) begin
                    check("oe_not_busy", {31'b0, dram_busy}, 32'd0);
                    check("oe_single_cycle", {31'b0, prev_oe}, 32'd0);
                    if (exp_dram.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_dram_oe: got addr %h want no request", dram_addr);
                    end else begin
                        dreq_t e;
                        e = exp_dram.pop_front();
                        check("dram_addr", dram_addr, e.addr);
                        check("dram_we", {28'b0, dram_we}, {28'b0, e.we});
                        if (e.chk_wd) check("dram_wdata", dram_wdata, e.wd);
                    end
                end
                prev_oe = dram_oe;
            end else begin
                prev_oe = 0;
            end
        end
    end

    // Wait (bounded) until every queued expectation has been consumed
    task automatic drain();
        int n = 0;
        while ((exp_resp.size() != 0 || exp_dram.size() != 0) && n < 200) begin
            @(negedge clk); n++;
        end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_resp.size());
            exp_resp.delete(); exp_dram.delete();
        end
        @(negedge clk);
    endtask

    // Issue one request; optionally expect a DRAM transaction and/or a 1-cycle hit
    task automatic req(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input bit use_dram,
                       input logic [31:0] d_addr, input logic [3:0] d_we,
                       input logic [31:0] d_wd, input bit is_hit);
        int n = 0;
        dreq_t e;
        exp_resp.push_back(exp_rd);
        if (use_dram) begin
            e.addr = d_addr; e.we = d_we; e.wd = d_wd; e.chk_wd = (we != 0);
            exp_dram.push_back(e);
        end
        @(negedge clk);
        req_valid = 1; req_addr = a; req_we = we; req_wdata = wd;
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge clk); n++;
        end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL accept_timeout: got req_ready %b want 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 0; req_we = 0;
        if (is_hit) begin
            @(negedge clk);
            check("hit_latency", {31'b0, resp_valid}, 32'd1);
        end
        drain();
    endtask

    initial begin
        rst_n = 0; calib_done = 0; flush = 0;
        req_valid = 0; req_addr = 0; req_we = 0; req_wdata = 0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_dram_oe", {31'b0, dram_oe}, 32'd0);
        check("rst_dram_addr", dram_addr, 32'd0);
        check("rst_dram_wdata", dram_wdata, 32'd0);
        check("rst_dram_we", {28'b0, dram_we}, 32'd0);
        rst_n = 1;

        // Calibration gating: request held for 20 cycles, never accepted
        req_valid = 1; req_addr = 32'h1000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("calib_ready", {31'b0, req_ready}, 32'd0);
        end
        req_valid = 0;
        calib_done = 1;

        // Cold read miss, then a repeat hit
        lat = 5; ret_data = 32'hDEADBEEF;
        req(32'h1000, 4'b0000, 0, 32'hDEADBEEF, 1, 32'h1000, 4'b0000, 0, 0);
        req(32'h1000, 4'b0000, 0, 32'hDEADBEEF, 0, 0, 0, 0, 1);
        // Byte store to resident line, merged data read back
        req(32'h1000, 4'b0100, 32'h00AB0000, 32'h0, 1, 32'h1002, 4'b0001, 32'h000000AB, 0);
        req(32'h1000, 4'b0000, 0, 32'hDEABBEEF, 0, 0, 0, 0, 1);
        // Halfword store miss does not allocate
        req(32'h2000, 4'b1100, 32'h12340000, 32'h0, 1, 32'h2002, 4'b0011, 32'h00001234, 0);
        ret_data = 32'h55667788;
        req(32'h2000, 4'b0000, 0, 32'h55667788, 1, 32'h2000, 4'b0000, 0, 0);
        // Conflict eviction on index 0
        ret_data = 32'h11111111;
        req(32'h1000, 4'b0000, 0, 32'h11111111, 1, 32'h1000, 4'b0000, 0, 0);
        ret_data = 32'h22222222;
        req(32'h1100, 4'b0000, 0, 32'h22222222, 1, 32'h1100, 4'b0000, 0, 0);
        ret_data = 32'h33333333;
        req(32'h1000, 4'b0000, 0, 32'h33333333, 1, 32'h1000, 4'b0000, 0, 0);
        // Other legal masks with read-after-write merging
        req(32'h1000, 4'b1111, 32'hCAFEF00D, 32'h0, 1, 32'h1000, 4'b1111, 32'hCAFEF00D, 0);
        req(32'h1000, 4'b0000, 0, 32'hCAFEF00D, 0, 0, 0, 0, 1);
        req(32'h1000, 4'b0011, 32'h0000BEEF, 32'h0, 1, 32'h1000, 4'b0011, 32'h0000BEEF, 0);
        req(32'h1000, 4'b1000, 32'h7F000000, 32'h0, 1, 32'h1003, 4'b0001, 32'h0000007F, 0);
        req(32'h1000, 4'b0000, 0, 32'h7FFEBEEF, 0, 0, 0, 0, 1);
        // Flush with two resident lines
        ret_data = 32'h00000044;
        req(32'h1008, 4'b0000, 0, 32'h00000044, 1, 32'h1008, 4'b0000, 0, 0);
        @(negedge clk);
        flush = 1;
        #1 check("flush_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        flush = 0;
        ret_data = 32'h00000005;
        req(32'h1000, 4'b0000, 0, 32'h00000005, 1, 32'h1000, 4'b0000, 0, 0);
        ret_data = 32'h00000006;
        req(32'h1008, 4'b0000, 0, 32'h00000006, 1, 32'h1008, 4'b0000, 0, 0);

        // Reset while waiting on DRAM with busy high
        begin
            dreq_t e;
            int n;
            lat = 8; ret_data = 32'hBAD0BAD0;
            e.addr = 32'h3000; e.we = 0; e.wd = 0; e.chk_wd = 0;
            exp_dram.push_back(e);
            @(negedge clk);
            req_valid = 1; req_addr = 32'h3000; req_we = 0;
            @(posedge clk); #1;
            req_valid = 0;
            n = 0;
            while (dram_busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            check("busy_before_rst", {31'b0, dram_busy}, 32'd1);
            @(negedge clk);
            rst_n = 0;
            #1;
            check("arst_req_ready", {31'b0, req_ready}, 32'd0);
            check("arst_resp_valid", {31'b0, resp_valid}, 32'd0);
            check("arst_dram_oe", {31'b0, dram_oe}, 32'd0);
            check("arst_dram_addr", dram_addr, 32'd0);
            check("arst_dram_we", {28'b0, dram_we}, 32'd0);
            @(negedge clk);
            rst_n = 1;
            n = 0;
            while (dram_busy === 1'b1 && n < 20) begin
                check("ready_while_busy", {31'b0, req_ready}, 32'd0);
                @(negedge clk); n++;
            end
            check("ready_after_busy", {31'b0, req_ready}, 32'd1);
            repeat (4) @(negedge clk);
        end
        // Lines do not survive reset
        lat = 5; ret_data = 32'h00000077;
        req(32'h1000, 4'b0000, 0, 32'h00000077, 1, 32'h1000, 4'b0000, 0, 0);

        check("resp_queue_empty", exp_resp.size(), 32'd0);
        check("dram_queue_empty", exp_dram.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dram_cache.md
# dram_cache

Direct-mapped, write-through, read-allocate word cache between the core's load/store port and the 32-bit DRAM request port. It serves read hits in one cycle and turns misses and all stores into single DRAM transactions. Before issuing a sub-word store, it converts the core's lane-positioned byte mask into the DRAM port's right-justified mask/offset form. It holds off all traffic until memory calibration completes.

## Interface
- `LINES`, 64: number of one-word lines; power of two, ≥2. `IDX = log2(LINES)`, tag = `addr[31:2+IDX]`.
- `clk` in 1: single clock; DRAM port runs on the same clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `calib_done` in 1: DRAM calibrated; no request accepted while low.
- `flush` in 1: pulse; invalidates all lines.
- `req_valid` in 1 / `req_ready` out 1: core request handshake.
- `req_addr` in 32: byte address; `[1:0]` ignored (word-aligned).
- `req_we` in 4: byte-lane write mask in word position; 0 = read.
- `req_wdata` in 32: store data in word position.
- `resp_valid` out 1: one-cycle pulse per accepted request.
- `resp_rdata` out 32: read data; 0 for writes.
- `dram_oe` out 1, `dram_addr` out 32, `dram_wdata` out 32, `dram_we` out 4: DRAM request, held valid for exactly one cycle.
- `dram_rdata` in 32, `dram_valid` in 1: DRAM read return, valid for one cycle.
- `dram_busy` in 1: DRAM transaction in flight; rises the cycle after `dram_oe`.

## Operation
- Storage: `valid[LINES]`, `tag[LINES]`, `data[LINES]` in registers. `valid` clears on reset; tag and data are not reset.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: `req_ready = calib_done & ~dram_busy & ~flush`. A request is accepted when `req_valid & req_ready`.
  - Read hit (`valid & tag match`): stay in IDLE; next cycle `resp_valid=1`, `resp_rdata=data[idx]`.
  - Read miss: go to ISSUE with `dram_addr={addr[31:2],2'b00}`, `dram_we=0`.
  - Write: go to ISSUE. On the accept edge, if the line hits, merge enabled bytes into `data[idx]`. A write miss does not allocate.
- Store mask conversion: `off` = index of the lowest set bit of `req_we`.
  - `dram_addr={addr[31:2],off}`, `dram_we=req_we>>off`, `dram_wdata=req_wdata>>(8*off)`.
  - Legal masks: 0001, 0010, 0100, 1000, 0011, 1100, 1111. Any other nonzero mask uses the same rule and is not otherwise checked.
- ISSUE: `dram_oe=1` for one cycle, then WAIT.
- WAIT:
  - Read completes on `dram_valid`: fill line `{valid=1, tag, data=dram_rdata}`; next cycle `resp_valid=1`, `resp_rdata=dram_rdata`; go to IDLE.
  - Write completes on the first WAIT cycle with `dram_busy==0`; next cycle `resp_valid=1`, `resp_rdata=0`; go to IDLE.
- `flush` in IDLE clears every `valid` in that cycle; no request is accepted that cycle. `flush` in ISSUE or WAIT is ignored (the caller holds it until `req_ready` has been seen).
- Reset (any state): FSM to IDLE, all valids cleared, every output 0. The DRAM side is not reset, so the gating on `~dram_busy` covers a transaction still in flight.

## Timing
- Reset values: `req_ready=0`, `resp_valid=0`, `resp_rdata=0`, `dram_oe=0`, `dram_addr=0`, `dram_wdata=0`, `dram_we=0`.
- All outputs are registered except `req_ready`, which is combinational from state, `calib_done`, `dram_busy` and `flush`.
- Read hit: accept at cycle A, `resp_valid` at A+1. Back-to-back hits sustain one per cycle.
- Miss/write: accept at A; `dram_oe` at A+1; WAIT from A+2; completion seen at cycle W; `resp_valid` at W+1, when `req_ready` may be 1 again.
- `dram_oe` is never asserted while `dram_busy=1` and is never high for two consecutive cycles.
- A read to a line written by the immediately preceding write returns the merged data, since the merge happens on the accept edge.

## Test plan
- Cold read 0x0000_1000, DRAM returns 0xDEADBEEF after 5 cycles -> one `dram_oe` with addr 0x1000 and we=0; `resp_rdata=0xDEADBEEF`. A repeat read hits: `resp_valid` one cycle after accept, no `dram_oe`.
- Store `req_we=4'b0100`, `req_wdata=0x00AB0000`, addr 0x1000 (line resident) -> `dram_addr=0x1002`, `dram_we=4'b0001`, `dram_wdata=0x000000AB`. A subsequent read hits and returns 0xDEABBEEF.
- Store `req_we=4'b1100`, data 0x12340000, addr 0x2000 (miss) -> `dram_addr=0x2002`, `dram_we=4'b0011`, `dram_wdata=0x1234`. The following read of 0x2000 misses.
- Conflict: read 0x1000, then read 0x1000+4·LINES -> second read misses and evicts; a third read of 0x1000 misses again.
- `calib_done=0` for 20 cycles with `req_valid=1` -> `req_ready=0`, no `dram_oe`. Apply `flush` with resident lines -> next read of any of them misses.
- Assert `rst_n` low during WAIT with `dram_busy` high -> outputs are 0 immediately. After release, `req_ready` stays 0 until `dram_busy` falls, and there is no `resp_valid` for the aborted request.
